// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, field bit positions,
// interrupt cause codes and the CSR operation encoding.
package csr_pkg;

    localparam logic [11:0] CsrMstatus   = 12'h300;
    localparam logic [11:0] CsrMisa      = 12'h301;
    localparam logic [11:0] CsrMie       = 12'h304;
    localparam logic [11:0] CsrMtvec     = 12'h305;
    localparam logic [11:0] CsrMscratch  = 12'h340;
    localparam logic [11:0] CsrMepc      = 12'h341;
    localparam logic [11:0] CsrMcause    = 12'h342;
    localparam logic [11:0] CsrMtval     = 12'h343;
    localparam logic [11:0] CsrMip       = 12'h344;
    localparam logic [11:0] CsrMcycle    = 12'hB00;
    localparam logic [11:0] CsrMinstret  = 12'hB02;
    localparam logic [11:0] CsrMcycleh   = 12'hB80;
    localparam logic [11:0] CsrMinstreth = 12'hB82;
    localparam logic [11:0] CsrMvendorid = 12'hF11;
    localparam logic [11:0] CsrMarchid   = 12'hF12;
    localparam logic [11:0] CsrMimpid    = 12'hF13;
    localparam logic [11:0] CsrMhartid   = 12'hF14;

    localparam int unsigned MstatusMieBit  = 3;
    localparam int unsigned MstatusMpieBit = 7;
    localparam int unsigned MstatusMppLo   = 11;
    localparam int unsigned MstatusMppHi   = 12;
    localparam int unsigned MisaIBit       = 8;

    localparam int unsigned CauseMsi = 3;
    localparam int unsigned CauseMti = 7;
    localparam int unsigned CauseMei = 11;

    // mie/mip bit positions coincide with the interrupt cause codes
    localparam int unsigned IrqMsiBit = CauseMsi;
    localparam int unsigned IrqMtiBit = CauseMti;
    localparam int unsigned IrqMeiBit = CauseMei;

    typedef enum logic [1:0] {
        CsrOpNone,
        CsrOpWrite,
        CsrOpSet,
        CsrOpClear
    } csr_op_e;

    function automatic csr_op_e csr_op_decode(input logic wr, input logic set, input logic clr);
        if (wr) return CsrOpWrite;
        if (set) return CsrOpSet;
        if (clr) return CsrOpClear;
        return CsrOpNone;
    endfunction

endpackage

// File: rtl/csr_mfile_if.sv
// CSR access bus between the execute stage (master) and the CSR file (slave).
interface csr_mfile_if #(
    parameter int unsigned XLEN = 32
);
    logic            csr_write;
    logic            csr_set;
    logic            csr_clear;
    logic            csr_read;
    logic [XLEN-1:0] csr_info;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_read_data;
    logic            csr_illegal;

    modport master (
        output csr_write, csr_set, csr_clear, csr_read, csr_info, csr_addr,
        input  csr_read_data, csr_illegal
    );

    modport slave (
        input  csr_write, csr_set, csr_clear, csr_read, csr_info, csr_addr,
        output csr_read_data, csr_illegal
    );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit wrapping counter with independently writable halves; a write to either half
// suppresses the increment for that cycle and leaves the other half untouched.
module csr_counter64 (
    input  logic        i_clk,
    input  logic        i_rst_b,
    input  logic        i_inc,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wdata_lo,
    input  logic [31:0] i_wdata_hi,
    output logic [63:0] o_count
);
    logic [63:0] r_count;
    logic [63:0] w_count_d;

    always_comb begin
        w_count_d = r_count;
        if (i_wr_lo || i_wr_hi) begin
            if (i_wr_lo) w_count_d[31:0] = i_wdata_lo;
            if (i_wr_hi) w_count_d[63:32] = i_wdata_hi;
        end else if (i_inc) begin
            w_count_d = r_count + 64'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_b) r_count <= '0;
        else         r_count <= w_count_d;
    end

    assign o_count = r_count;
endmodule

// File: rtl/csr_mfile.sv
// Machine-mode CSR file: architected M-mode registers, trap entry / MRET updates,
// cycle and instret counters, interrupt pending logic and illegal-access detection.
module csr_mfile
    import csr_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] HART_ID     = '0,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0,
    parameter bit              VECTORED_EN = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_b,
    csr_mfile_if.slave      bus,
    input  logic            i_trap_valid,
    input  logic [XLEN-1:0] i_trap_cause,
    input  logic [XLEN-1:0] i_trap_pc,
    input  logic [XLEN-1:0] i_trap_tval,
    input  logic            i_mret,
    input  logic            i_instret_inc,
    input  logic            i_irq_software,
    input  logic            i_irq_timer,
    input  logic            i_irq_external,
    output logic            o_irq_pending,
    output logic [XLEN-1:0] o_trap_vector,
    output logic [XLEN-1:0] o_mepc_out
);
    localparam logic [XLEN-1:0] MtvecClr = VECTORED_EN ? XLEN'(2) : XLEN'(3);
    localparam logic [XLEN-1:0] Align4   = XLEN'(3);

    logic [XLEN-1:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
    logic            r_st_mie, r_st_mpie;
    logic [2:0]      r_mie_en, r_mip;  // {MEI, MTI, MSI}

    logic [63:0]     w_cycle, w_instret;
    logic [XLEN-1:0] w_rdata, w_wdata, w_mstatus, w_mie_val, w_mip_val, w_misa;
    logic [XLEN-1:0] w_tvec_base;
    logic            w_impl, w_ro, w_access, w_illegal, w_wen;
    csr_op_e         w_op;
    logic [31:0]     w_cnt_wdata_lo, w_cnt_wdata_hi;
    logic            w_cyc_wr_lo, w_cyc_wr_hi, w_ret_wr_lo, w_ret_wr_hi;

    assign w_op = csr_op_decode(bus.csr_write, bus.csr_set, bus.csr_clear);

    always_comb begin
        w_mstatus = '0;
        w_mstatus[MstatusMieBit] = r_st_mie;
        w_mstatus[MstatusMpieBit] = r_st_mpie;
        w_mstatus[MstatusMppHi:MstatusMppLo] = 2'b11;
        w_mie_val = '0;
        w_mie_val[IrqMsiBit] = r_mie_en[0];
        w_mie_val[IrqMtiBit] = r_mie_en[1];
        w_mie_val[IrqMeiBit] = r_mie_en[2];
        w_mip_val = '0;
        w_mip_val[IrqMsiBit] = r_mip[0];
        w_mip_val[IrqMtiBit] = r_mip[1];
        w_mip_val[IrqMeiBit] = r_mip[2];
        w_misa = '0;
        w_misa[XLEN-1 -: 2] = (XLEN == 64) ? 2'd2 : 2'd1;
        w_misa[MisaIBit] = 1'b1;
    end

    always_comb begin
        w_rdata = '0;
        w_impl = 1'b1;
        case (bus.csr_addr)
            CsrMstatus:  w_rdata = w_mstatus;
            CsrMisa:     w_rdata = w_misa;
            CsrMie:      w_rdata = w_mie_val;
            CsrMtvec:    w_rdata = r_mtvec;
            CsrMscratch: w_rdata = r_mscratch;
            CsrMepc:     w_rdata = r_mepc;
            CsrMcause:   w_rdata = r_mcause;
            CsrMtval:    w_rdata = r_mtval;
            CsrMip:      w_rdata = w_mip_val;
            CsrMcycle:   w_rdata = XLEN'(w_cycle);
            CsrMinstret: w_rdata = XLEN'(w_instret);
            CsrMcycleh: begin
                if (XLEN == 32) w_rdata = XLEN'(w_cycle[63:32]);
                else            w_impl = 1'b0;
            end
            CsrMinstreth: begin
                if (XLEN == 32) w_rdata = XLEN'(w_instret[63:32]);
                else            w_impl = 1'b0;
            end
            CsrMvendorid, CsrMarchid, CsrMimpid: w_rdata = '0;
            CsrMhartid:  w_rdata = HART_ID;
            default:     w_impl = 1'b0;
        endcase
    end

    assign w_ro = (bus.csr_addr[11:10] == 2'b11) || (bus.csr_addr == CsrMip);
    assign w_access = bus.csr_read | bus.csr_write | bus.csr_set | bus.csr_clear;
    // Set/clear with a zero mask is a pure read and therefore legal on read-only CSRs
    assign w_illegal = w_access &
        (~w_impl | (w_ro & (bus.csr_write | ((bus.csr_set | bus.csr_clear) & |bus.csr_info))));
    assign w_wen = (w_op != CsrOpNone) && !w_illegal;

    always_comb begin
        case (w_op)
            CsrOpSet:   w_wdata = bus.csr_info | w_rdata;
            CsrOpClear: w_wdata = ~bus.csr_info & w_rdata;
            default:    w_wdata = bus.csr_info;
        endcase
    end

    assign bus.csr_read_data = w_rdata;
    assign bus.csr_illegal = w_illegal;

    always_ff @(posedge i_clk) begin
        if (i_rst_b) begin
            r_st_mie   <= 1'b0;
            r_st_mpie  <= 1'b0;
            r_mie_en   <= '0;
            r_mip      <= '0;
            r_mtvec    <= MTVEC_RESET;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
        end else begin
            r_mip <= {i_irq_external, i_irq_timer, i_irq_software};
            if (w_wen && bus.csr_addr == CsrMie)
                r_mie_en <= {w_wdata[IrqMeiBit], w_wdata[IrqMtiBit], w_wdata[IrqMsiBit]};
            if (w_wen && bus.csr_addr == CsrMtvec) r_mtvec <= w_wdata & ~MtvecClr;
            if (w_wen && bus.csr_addr == CsrMscratch) r_mscratch <= w_wdata;
            // Trap beats MRET, which beats a CSR write, on the fields they share
            if (i_trap_valid) begin
                r_mepc    <= i_trap_pc & ~Align4;
                r_mcause  <= i_trap_cause;
                r_mtval   <= i_trap_tval;
                r_st_mpie <= r_st_mie;
                r_st_mie  <= 1'b0;
            end else begin
                if (w_wen && bus.csr_addr == CsrMepc) r_mepc <= w_wdata & ~Align4;
                if (w_wen && bus.csr_addr == CsrMcause) r_mcause <= w_wdata;
                if (w_wen && bus.csr_addr == CsrMtval) r_mtval <= w_wdata;
                if (i_mret) begin
                    r_st_mie  <= r_st_mpie;
                    r_st_mpie <= 1'b1;
                end else if (w_wen && bus.csr_addr == CsrMstatus) begin
                    r_st_mie  <= w_wdata[MstatusMieBit];
                    r_st_mpie <= w_wdata[MstatusMpieBit];
                end
            end
        end
    end

    if (XLEN == 64) begin : g_xlen64
        assign w_cnt_wdata_lo = w_wdata[31:0];
        assign w_cnt_wdata_hi = w_wdata[XLEN-1:32];
        assign w_cyc_wr_lo = w_wen && (bus.csr_addr == CsrMcycle);
        assign w_cyc_wr_hi = w_cyc_wr_lo;
        assign w_ret_wr_lo = w_wen && (bus.csr_addr == CsrMinstret);
        assign w_ret_wr_hi = w_ret_wr_lo;
    end else begin : g_xlen32
        assign w_cnt_wdata_lo = w_wdata[31:0];
        assign w_cnt_wdata_hi = w_wdata[31:0];
        assign w_cyc_wr_lo = w_wen && (bus.csr_addr == CsrMcycle);
        assign w_cyc_wr_hi = w_wen && (bus.csr_addr == CsrMcycleh);
        assign w_ret_wr_lo = w_wen && (bus.csr_addr == CsrMinstret);
        assign w_ret_wr_hi = w_wen && (bus.csr_addr == CsrMinstreth);
    end

    csr_counter64 u_mcycle (
        .i_clk      (i_clk),
        .i_rst_b    (i_rst_b),
        .i_inc      (1'b1),
        .i_wr_lo    (w_cyc_wr_lo),
        .i_wr_hi    (w_cyc_wr_hi),
        .i_wdata_lo (w_cnt_wdata_lo),
        .i_wdata_hi (w_cnt_wdata_hi),
        .o_count    (w_cycle)
    );

    csr_counter64 u_minstret (
        .i_clk      (i_clk),
        .i_rst_b    (i_rst_b),
        .i_inc      (i_instret_inc),
        .i_wr_lo    (w_ret_wr_lo),
        .i_wr_hi    (w_ret_wr_hi),
        .i_wdata_lo (w_cnt_wdata_lo),
        .i_wdata_hi (w_cnt_wdata_hi),
        .o_count    (w_instret)
    );

    assign w_tvec_base = r_mtvec & ~Align4;
    assign o_trap_vector = (r_mtvec[0] && i_trap_cause[XLEN-1])
                         ? w_tvec_base + {i_trap_cause[XLEN-3:0], 2'b00}
                         : w_tvec_base;
    assign o_mepc_out = r_mepc;
    assign o_irq_pending = !i_rst_b && r_st_mie && |(r_mip & r_mie_en);
endmodule

// File: tb/tb_csr_mfile.sv
// Self-checking bench for csr_mfile (XLEN=32): directed scenarios plus randomized traffic
// compared against an address-level reference model of the CSR file.
module tb_csr_mfile;
    localparam logic [31:0] HartId = 32'd3;
    localparam logic [31:0] MtvecRst = 32'h0000_0400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trap_valid = 1'b0, mret = 1'b0, instret_inc = 1'b0;
    logic [31:0] trap_cause = '0, trap_pc = '0, trap_tval = '0;
    logic        irq_s = 1'b0, irq_t = 1'b0, irq_e = 1'b0;
    logic        irq_pending;
    logic [31:0] trap_vector, mepc_out;
    int          n_checks = 0, n_pass = 0;

    logic [31:0] m_mstatus, m_mie, m_mip, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_cycle, m_instret;

    always #5 clk = ~clk;

    csr_mfile_if #(.XLEN(32)) bus ();

    csr_mfile #(
        .XLEN        (32),
        .HART_ID     (HartId),
        .MTVEC_RESET (MtvecRst),
        .VECTORED_EN (1'b1)
    ) dut (
        .i_clk          (clk),
        .i_rst_b        (rst),
        .bus            (bus),
        .i_trap_valid   (trap_valid),
        .i_trap_cause   (trap_cause),
        .i_trap_pc      (trap_pc),
        .i_trap_tval    (trap_tval),
        .i_mret         (mret),
        .i_instret_inc  (instret_inc),
        .i_irq_software (irq_s),
        .i_irq_timer    (irq_t),
        .i_irq_external (irq_e),
        .o_irq_pending  (irq_pending),
        .o_trap_vector  (trap_vector),
        .o_mepc_out     (mepc_out)
    );

    // ---------------- reference model ----------------
    function automatic bit m_impl(input logic [11:0] a);
        return a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                         12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF11,
                         12'hF12, 12'hF13, 12'hF14};
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus | 32'h0000_1800;
            12'h301: return 32'h4000_0100;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return m_mip;
            12'hB00: return m_cycle[31:0];
            12'hB80: return m_cycle[63:32];
            12'hB02: return m_instret[31:0];
            12'hB82: return m_instret[63:32];
            12'hF14: return HartId;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_illegal();
        bit ro, any;
        ro = (bus.csr_addr[11:10] == 2'b11) || (bus.csr_addr == 12'h344);
        any = bus.csr_read || bus.csr_write || bus.csr_set || bus.csr_clear;
        if (!any) return 1'b0;
        if (!m_impl(bus.csr_addr)) return 1'b1;
        return ro && (bus.csr_write || ((bus.csr_set || bus.csr_clear) && bus.csr_info != 0));
    endfunction

    function automatic logic [31:0] m_tvec(input logic [31:0] cause);
        logic [31:0] base;
        base = m_mtvec & 32'hFFFF_FFFC;
        if (m_mtvec[0] && cause[31]) return base + (cause << 2);
        return base;
    endfunction

    function automatic bit m_pending();
        return !rst && m_mstatus[3] && ((m_mip & m_mie) != 0);
    endfunction

    // Advance the model by one clock using the inputs currently driven, then clock the DUT.
    task automatic step();
        logic [31:0] rd, wd, st;
        logic [63:0] c0, i0;
        bit wen;
        if (rst) begin
            m_mstatus = 0; m_mie = 0; m_mip = 0; m_mtvec = MtvecRst; m_mscratch = 0;
            m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cycle = 0; m_instret = 0;
        end else begin
            rd = m_read(bus.csr_addr);
            wd = bus.csr_write ? bus.csr_info
               : bus.csr_set ? (bus.csr_info | rd) : (~bus.csr_info & rd);
            wen = (bus.csr_write || bus.csr_set || bus.csr_clear) && !m_illegal();
            st = m_mstatus;
            c0 = m_cycle;
            i0 = m_instret;
            m_cycle = c0 + 64'd1;
            if (instret_inc) m_instret = i0 + 64'd1;
            if (wen) begin
                case (bus.csr_addr)
                    12'h300: if (!trap_valid && !mret) m_mstatus = wd & 32'h88;
                    12'h304: m_mie = wd & 32'h888;
                    12'h305: m_mtvec = wd & 32'hFFFF_FFFD;
                    12'h340: m_mscratch = wd;
                    12'h341: if (!trap_valid) m_mepc = wd & 32'hFFFF_FFFC;
                    12'h342: if (!trap_valid) m_mcause = wd;
                    12'h343: if (!trap_valid) m_mtval = wd;
                    12'hB00: m_cycle = {c0[63:32], wd};
                    12'hB80: m_cycle = {wd, c0[31:0]};
                    12'hB02: m_instret = {i0[63:32], wd};
                    12'hB82: m_instret = {wd, i0[31:0]};
                    default: ;
                endcase
            end
            if (trap_valid) begin
                m_mepc = trap_pc & 32'hFFFF_FFFC;
                m_mcause = trap_cause;
                m_mtval = trap_tval;
                m_mstatus = st[3] ? 32'h80 : 32'h0;
            end else if (mret) begin
                m_mstatus = (st[7] ? 32'h8 : 32'h0) | 32'h80;
            end
            m_mip = (32'(irq_e) << 11) | (32'(irq_t) << 7) | (32'(irq_s) << 3);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit w, input bit s, input bit c, input bit r,
                         input logic [11:0] a, input logic [31:0] info);
        bus.csr_write = w; bus.csr_set = s; bus.csr_clear = c; bus.csr_read = r;
        bus.csr_addr = a; bus.csr_info = info;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 12'h000, 32'h0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [11:0] tab [7] = '{12'h300, 12'h301, 12'h304, 12'h344, 12'hF11, 12'hF14, 12'h340};
        rst = 1'b1;
        idle();
        trap_cause = 32'h8000_0007;
        repeat (3) step();
        drive(0, 0, 0, 1, 12'h305, 32'h0);
        #1;
        n_checks++; if (irq_pending !== 1'b0) $display("FAIL rst_irq_pending: got %b want 0", irq_pending); else n_pass++;
        n_checks++; if (trap_vector !== MtvecRst) $display("FAIL rst_trap_vector: got %h want %h", trap_vector, MtvecRst); else n_pass++;
        n_checks++; if (bus.csr_read_data !== MtvecRst) $display("FAIL rst_mtvec: got %h want %h", bus.csr_read_data, MtvecRst); else n_pass++;
        rst = 1'b0;
        idle();
        repeat (10) step();
        drive(0, 0, 0, 1, 12'hB00, 32'h0);
        #1;
        n_checks++; if (bus.csr_read_data !== 32'd10) $display("FAIL mcycle_after_10: got %0d want 10", bus.csr_read_data); else n_pass++;
        drive(0, 0, 0, 1, 12'hB80, 32'h0);
        #1;
        n_checks++; if (bus.csr_read_data !== 32'd0) $display("FAIL mcycleh_after_10: got %h want 0", bus.csr_read_data); else n_pass++;
        foreach (tab[i]) begin
            drive(0, 0, 0, 1, tab[i], 32'h0);
            #1;
            n_checks++; if (bus.csr_read_data !== m_read(tab[i])) $display("FAIL rst_read_%h: got %h want %h", tab[i], bus.csr_read_data, m_read(tab[i])); else n_pass++;
        end
        idle();
    endtask

    task automatic test_rmw();
        logic [31:0] ops [3] = '{32'hA5A5_0000, 32'h0000_00FF, 32'hA500_0000};
        for (int i = 0; i < 3; i++) begin
            drive(i == 0, i == 1, i == 2, 1'b0, 12'h340, ops[i]);
            #1;
            n_checks++; if (bus.csr_illegal !== 1'b0) $display("FAIL rmw_illegal_%0d: got %b want 0", i, bus.csr_illegal); else n_pass++;
            step();
        end
        drive(0, 0, 0, 1, 12'h340, 32'h0);
        #1;
        n_checks++; if (bus.csr_read_data !== 32'h00A5_00FF) $display("FAIL rmw_value: got %h want 00a500ff", bus.csr_read_data); else n_pass++;
        idle();
    endtask

    task automatic test_illegal();
        drive(1, 0, 0, 0, 12'hF14, 32'h123);
        #1;
        n_checks++; if (bus.csr_illegal !== 1'b1) $display("FAIL ill_write_hartid: got %b want 1", bus.csr_illegal); else n_pass++;
        step();
        drive(0, 0, 0, 1, 12'hF14, 32'h0);
        #1;
        n_checks++; if (bus.csr_read_data !== HartId) $display("FAIL hartid_unchanged: got %h want %h", bus.csr_read_data, HartId); else n_pass++;
        n_checks++; if (bus.csr_illegal !== 1'b0) $display("FAIL ill_read_hartid: got %b want 0", bus.csr_illegal); else n_pass++;
        drive(0, 0, 0, 1, 12'h7C0, 32'h0);
        #1;
        n_checks++; if (bus.csr_illegal !== 1'b1) $display("FAIL ill_read_unimpl: got %b want 1", bus.csr_illegal); else n_pass++;
        drive(0, 1, 0, 0, 12'hF14, 32'h0);
        #1;
        n_checks++; if (bus.csr_illegal !== 1'b0) $display("FAIL ill_set_zero_ro: got %b want 0", bus.csr_illegal); else n_pass++;
        drive(0, 0, 1, 0, 12'h344, 32'h80);
        #1;
        n_checks++; if (bus.csr_illegal !== 1'b1) $display("FAIL ill_clear_mip: got %b want 1", bus.csr_illegal); else n_pass++;
        drive(0, 0, 0, 1, 12'hB82, 32'h0);
        #1;
        n_checks++; if (bus.csr_illegal !== 1'b0) $display("FAIL ill_read_minstreth: got %b want 0", bus.csr_illegal); else n_pass++;
        idle();
    endtask

    task automatic test_trap();
        drive(1, 0, 0, 0, 12'h300, 32'h8);
        step();
        trap_valid = 1'b1; trap_cause = 32'd2; trap_pc = 32'h0000_1003; trap_tval = 32'hDEAD;
        drive(1, 0, 0, 0, 12'h340, 32'h77);
        step();
        trap_valid = 1'b0;
        idle();
        #1;
        n_checks++; if (mepc_out !== 32'h1000) $display("FAIL trap_mepc_out: got %h want 00001000", mepc_out); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            logic [11:0] a;
            logic [31:0] want;
            case (i)
                0: begin a = 12'h341; want = 32'h0000_1000; end
                1: begin a = 12'h342; want = 32'h0000_0002; end
                2: begin a = 12'h343; want = 32'h0000_DEAD; end
                3: begin a = 12'h300; want = 32'h0000_1880; end
                default: begin a = 12'h340; want = 32'h0000_0077; end
            endcase
            drive(0, 0, 0, 1, a, 32'h0);
            #1;
            n_checks++; if (bus.csr_read_data !== want) $display("FAIL trap_read_%h: got %h want %h", a, bus.csr_read_data, want); else n_pass++;
        end
        mret = 1'b1;
        drive(1, 0, 0, 0, 12'h300, 32'h0);
        step();
        mret = 1'b0;
        drive(0, 0, 0, 1, 12'h300, 32'h0);
        #1;
        n_checks++; if (bus.csr_read_data !== 32'h1888) $display("FAIL mret_mstatus: got %h want 00001888", bus.csr_read_data); else n_pass++;
        trap_valid = 1'b1; trap_pc = 32'h0000_2002;
        drive(1, 0, 0, 0, 12'h341, 32'hFFFF);
        step();
        trap_valid = 1'b0;
        idle();
        #1;
        n_checks++; if (mepc_out !== 32'h2000) $display("FAIL trap_beats_write: got %h want 00002000", mepc_out); else n_pass++;
    endtask

    task automatic test_irq();
        drive(1, 0, 0, 0, 12'h300, 32'h88);
        step();
        drive(1, 0, 0, 0, 12'h305, 32'h103);
        step();
        drive(1, 0, 0, 0, 12'h304, 32'h80);
        step();
        drive(0, 0, 0, 1, 12'h305, 32'h0);
        #1;
        n_checks++; if (bus.csr_read_data !== 32'h101) $display("FAIL mtvec_bit1: got %h want 00000101", bus.csr_read_data); else n_pass++;
        irq_t = 1'b1;
        drive(0, 0, 0, 1, 12'h344, 32'h0);
        #1;
        n_checks++; if (bus.csr_read_data !== 32'h0) $display("FAIL mip_lag: got %h want 0", bus.csr_read_data); else n_pass++;
        n_checks++; if (irq_pending !== 1'b0) $display("FAIL pending_lag: got %b want 0", irq_pending); else n_pass++;
        step();
        n_checks++; if (bus.csr_read_data !== 32'h80) $display("FAIL mip_mtip: got %h want 00000080", bus.csr_read_data); else n_pass++;
        n_checks++; if (irq_pending !== 1'b1) $display("FAIL pending_set: got %b want 1", irq_pending); else n_pass++;
        trap_cause = 32'h8000_0007;
        #1;
        n_checks++; if (trap_vector !== 32'h11C) $display("FAIL vector_irq7: got %h want 0000011c", trap_vector); else n_pass++;
        trap_cause = 32'd2;
        #1;
        n_checks++; if (trap_vector !== 32'h100) $display("FAIL vector_exc: got %h want 00000100", trap_vector); else n_pass++;
        drive(0, 0, 1, 0, 12'h300, 32'h8);
        step();
        n_checks++; if (irq_pending !== 1'b0) $display("FAIL pending_mie_off: got %b want 0", irq_pending); else n_pass++;
        irq_t = 1'b0;
        idle();
    endtask

    task automatic test_counters();
        drive(1, 0, 0, 0, 12'hB00, 32'hFFFF_FFFF);
        step();
        drive(1, 0, 0, 0, 12'hB80, 32'hFFFF_FFFF);
        step();
        drive(0, 0, 0, 1, 12'hB00, 32'h0);
        #1;
        n_checks++; if (bus.csr_read_data !== 32'hFFFF_FFFF) $display("FAIL cyc_lo_max: got %h want ffffffff", bus.csr_read_data); else n_pass++;
        drive(0, 0, 0, 1, 12'hB80, 32'h0);
        #1;
        n_checks++; if (bus.csr_read_data !== 32'hFFFF_FFFF) $display("FAIL cyc_hi_max: got %h want ffffffff", bus.csr_read_data); else n_pass++;
        step();
        n_checks++; if (bus.csr_read_data !== 32'h0) $display("FAIL cyc_hi_wrap: got %h want 0", bus.csr_read_data); else n_pass++;
        drive(0, 0, 0, 1, 12'hB00, 32'h0);
        #1;
        n_checks++; if (bus.csr_read_data !== 32'h0) $display("FAIL cyc_lo_wrap: got %h want 0", bus.csr_read_data); else n_pass++;
        drive(1, 0, 0, 0, 12'hB00, 32'h1234);
        step();
        n_checks++; if (bus.csr_read_data !== 32'h1234) $display("FAIL cyc_write_wins: got %h want 00001234", bus.csr_read_data); else n_pass++;
        instret_inc = 1'b1;
        drive(1, 0, 0, 0, 12'hB02, 32'h50);
        step();
        drive(0, 0, 0, 1, 12'hB02, 32'h0);
        #1;
        n_checks++; if (bus.csr_read_data !== 32'h50) $display("FAIL ret_write_wins: got %h want 00000050", bus.csr_read_data); else n_pass++;
        step();
        n_checks++; if (bus.csr_read_data !== 32'h51) $display("FAIL ret_inc: got %h want 00000051", bus.csr_read_data); else n_pass++;
        instret_inc = 1'b0;
        idle();
    endtask

    task automatic test_random();
        logic [11:0] tab [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                  12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF11,
                                  12'hF14, 12'h7C0, 12'h3A0, 12'hF15, 12'hB81, 12'h306};
        for (int it = 0; it < 300; it++) begin
            int op;
            logic [31:0] info;
            op = int'($urandom_range(0, 4));
            info = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            drive(op == 1, op == 2, op == 3, op == 4, tab[$urandom_range(0, 19)], info);
            trap_valid = ($urandom_range(0, 15) == 0);
            mret = !trap_valid && ($urandom_range(0, 15) == 0);
            trap_cause = $urandom; trap_pc = $urandom; trap_tval = $urandom;
            instret_inc = $urandom_range(0, 1) == 1;
            irq_s = $urandom_range(0, 1) == 1;
            irq_t = $urandom_range(0, 1) == 1;
            irq_e = $urandom_range(0, 1) == 1;
            #1;
            n_checks++; if (bus.csr_read_data !== m_read(bus.csr_addr)) $display("FAIL rnd_read it=%0d addr=%h: got %h want %h", it, bus.csr_addr, bus.csr_read_data, m_read(bus.csr_addr)); else n_pass++;
            n_checks++; if (bus.csr_illegal !== m_illegal()) $display("FAIL rnd_illegal it=%0d addr=%h: got %b want %b", it, bus.csr_addr, bus.csr_illegal, m_illegal()); else n_pass++;
            n_checks++; if (irq_pending !== m_pending()) $display("FAIL rnd_pending it=%0d: got %b want %b", it, irq_pending, m_pending()); else n_pass++;
            n_checks++; if (trap_vector !== m_tvec(trap_cause)) $display("FAIL rnd_vector it=%0d: got %h want %h", it, trap_vector, m_tvec(trap_cause)); else n_pass++;
            n_checks++; if (mepc_out !== m_mepc) $display("FAIL rnd_mepc it=%0d: got %h want %h", it, mepc_out, m_mepc); else n_pass++;
            step();
        end
        trap_valid = 1'b0; mret = 1'b0; instret_inc = 1'b0;
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rmw();
        test_illegal();
        test_trap();
        test_irq();
        test_counters();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
